emac_rx_gtx: RTL and testbench
==============================

# emac_rx_gtx

Receive-side GMII framer for the 1G SFP path. It samples GMII receive bytes and strips preamble and SFD. It checks the Ethernet CRC-32 and frame length, removes the 4-byte FCS, and delivers payload bytes with start/end markers and a good/bad verdict to the packet parser. It is the counterpart of the GMII transmit framer on the same link and runs in the same GMII clock domain.

## Interface
- MIN_LEN, 64, minimum good frame length in bytes, DA through FCS inclusive
- MAX_LEN, 1518, maximum good frame length in bytes, DA through FCS inclusive; must be ≤ 2046
- clk  in  1  GMII receive clock, 125 MHz
- rst_n  in  1  reset, asynchronous, active-low
- gmii_rxd  in  8  receive byte
- gmii_rx_dv  in  1  receive data valid
- gmii_rx_er  in  1  receive error
- rx_data  out  8  payload byte (DA … last byte before FCS)
- rx_data_valid  out  1  rx_data qualifier
- rx_sof  out  1  high with the first rx_data_valid beat of a frame
- rx_eof  out  1  one-cycle end-of-frame pulse, rx_data_valid low in that cycle
- rx_good  out  1  valid only with rx_eof: frame passed CRC, length and error checks
- rx_bad  out  1  valid only with rx_eof: exactly ~rx_good
- rx_frame_cnt  out  16  count of good frames, saturating
- rx_err_cnt  out  16  count of bad frames, saturating

## Operation
- **Input register.** gmii_rxd, gmii_rx_dv and gmii_rx_er are registered once into rxd_r, dv_r and er_r. All decisions use the registered values. rxd is ignored whenever dv_r = 0, including the K/idle/end codes sent while tx_en is low.
- **States:** IDLE, PRE, DATA, DROP.
  - IDLE: dv_r & rxd_r=0x55 → PRE. dv_r with any other byte → DROP.
  - PRE: rxd_r=0x55 → stay. rxd_r=0xD5 → DATA; clear CRC to 0xFFFFFFFF, byte count to 0, shift-register fill to 0, and the error flag. Other byte → DROP. dv_r=0 → IDLE. No outputs and no counts in this state.
  - DATA, dv_r=1: byte count +1; CRC updated with rxd_r; rxd_r pushed into a 4-byte shift register. Once the fill is 4, the oldest byte goes to rx_data with rx_data_valid=1. rx_sof is set on the first such beat. er_r=1 sets the error flag.
  - DATA, dv_r=0 → IDLE and finalize.
  - DATA, byte count would exceed MAX_LEN → DROP. That same edge issues rx_eof with rx_bad=1 and increments rx_err_cnt. No further data is emitted.
  - DROP: dv_r=0 → IDLE. Emits no outputs.
- **Finalize.**
  - good = (CRC register = 0xDEBB20E3) & MIN_LEN ≤ count ≤ MAX_LEN & ~error flag.
  - If count ≥ 5: pulse rx_eof with rx_good/rx_bad, and increment rx_frame_cnt (good) or rx_err_cnt (bad).
  - If count ≤ 4: no beats were emitted, no rx_eof; rx_err_cnt increments.
- **CRC.** CRC-32, reflected polynomial 0xEDB88320, LSB-first byte processing, init 0xFFFFFFFF. Computed over every byte after SFD, including the FCS. No final inversion; a correct frame leaves the residue 0xDEBB20E3.
- **Byte counter.** 11 bits, saturating.
- **Statistics counters.** Saturate at 0xFFFF and never wrap.
- **Reset.** Async assertion clears state to IDLE, the shift register, the CRC state and all flags immediately. All outputs go to 0: rx_data=0x00, valid/sof/eof/good/bad=0, both counters=0. Reset mid-frame discards the frame with no rx_eof. After deassertion, a frame already in progress without its preamble is ignored until dv falls.

## Timing
- Latency: a byte on gmii_rxd in cycle n appears on rx_data in cycle n+6 (input register, 4-deep FCS line, output register).
- The last payload byte is emitted in the cycle the last FCS byte is in rxd_r. rx_eof follows in the next cycle, and the last FCS byte is never emitted.
- Output is contiguous: rx_data_valid never gaps inside a frame while gmii_rx_dv is contiguous.
- Back-to-back frames: one idle cycle (dv low) between frames is sufficient. rx_eof of frame A precedes rx_sof of frame B by at least 6 cycles.
- rx_data is don't-care when rx_data_valid=0. rx_good and rx_bad are 0 outside rx_eof.

## Test plan
- **Minimum good frame.** 7×0x55, 0xD5, 60 bytes 0x00..0x3B, correct FCS → 60 beats 0x00..0x3B; first beat 6 cycles after the first data byte, with rx_sof; then rx_eof with rx_good=1; rx_frame_cnt=1.
- **CRC error.** Same frame with the last FCS byte XOR 0x01 → 60 beats, rx_eof with rx_bad=1, rx_err_cnt=1, rx_frame_cnt unchanged.
- **Runt and short preambles.** 63-byte frame with correct FCS → 59 beats, rx_bad=1. Separately, a 3-byte frame → no beats, no rx_eof, rx_err_cnt+1. Separately, a preamble of 1×0x55 then 0xD5 is accepted.
- **Oversize and rx_er.** 1519-byte frame → 1514 beats, then rx_eof with rx_bad at byte 1519, with no further output. Separately, gmii_rx_er pulsed at byte 20 of a good 100-byte frame → 96 beats, rx_bad=1.
- **Back-to-back and ignored bytes.** Two good 64-byte frames with a 1-cycle dv gap, and 0xFD/0xF7/0xBC present on rxd while dv=0 → two clean frames, rx_frame_cnt=2, no spurious beats.
- **Reset mid-frame.** rst_n low at byte 30 → all outputs 0 asynchronously, counters 0, no rx_eof. After release, the next good frame is received normally.

Source files
------------

// File: rtl/emac_rx_gtx.sv
// Receive-side GMII framer: strips preamble/SFD, checks CRC-32 and length,
// drops the FCS and hands payload bytes with sof/eof and a good/bad verdict.
module emac_rx_gtx #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  gmii_rxd,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  output logic [7:0]  rx_data,
  output logic        rx_data_valid,
  output logic        rx_sof,
  output logic        rx_eof,
  output logic        rx_good,
  output logic        rx_bad,
  output logic [15:0] rx_frame_cnt,
  output logic [15:0] rx_err_cnt
);

  localparam logic [10:0] MIN_C   = 11'(MIN_LEN);
  localparam logic [10:0] MAX_C   = 11'(MAX_LEN);
  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

  state_t      state;
  logic [7:0]  rxd_r;
  logic        dv_r;
  logic        er_r;
  logic [31:0] crc;
  logic [10:0] cnt;
  logic [2:0]  fill;
  logic [31:0] sr;
  logic        err_flag;
  logic        sof_pend;
  logic [31:0] crc_nxt;
  logic        good_now;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [10:0] sat_inc11(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  assign crc_nxt  = crc_byte(crc, rxd_r);
  assign good_now = (crc == RESIDUE) && (cnt >= MIN_C) && (cnt <= MAX_C) && !err_flag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rxd_r         <= 8'h00;
      dv_r          <= 1'b0;
      er_r          <= 1'b0;
      crc           <= 32'hFFFFFFFF;
      cnt           <= 11'd0;
      fill          <= 3'd0;
      sr            <= 32'h0;
      err_flag      <= 1'b0;
      sof_pend      <= 1'b0;
      rx_data       <= 8'h00;
      rx_data_valid <= 1'b0;
      rx_sof        <= 1'b0;
      rx_eof        <= 1'b0;
      rx_good       <= 1'b0;
      rx_bad        <= 1'b0;
      rx_frame_cnt  <= 16'h0;
      rx_err_cnt    <= 16'h0;
    end else begin
      rxd_r         <= gmii_rxd;
      dv_r          <= gmii_rx_dv;
      er_r          <= gmii_rx_er;
      rx_data_valid <= 1'b0;
      rx_sof        <= 1'b0;
      rx_eof        <= 1'b0;
      rx_good       <= 1'b0;
      rx_bad        <= 1'b0;
      unique case (state)
        IDLE: begin
          if (dv_r) state <= (rxd_r == 8'h55) ? PRE : DROP;
        end
        PRE: begin
          if (!dv_r) begin
            state <= IDLE;
          end else if (rxd_r == 8'hD5) begin
            state    <= DATA;
            crc      <= 32'hFFFFFFFF;
            cnt      <= 11'd0;
            fill     <= 3'd0;
            err_flag <= 1'b0;
            sof_pend <= 1'b1;
          end else if (rxd_r != 8'h55) begin
            state <= DROP;
          end
        end
        DATA: begin
          if (!dv_r) begin
            state <= IDLE;
            if (cnt >= 11'd5) begin
              rx_eof <= 1'b1;
              rx_good <= good_now;
              rx_bad  <= !good_now;
              if (good_now) rx_frame_cnt <= sat_inc16(rx_frame_cnt);
              else          rx_err_cnt   <= sat_inc16(rx_err_cnt);
            end else begin
              rx_err_cnt <= sat_inc16(rx_err_cnt);
            end
          end else if (cnt >= MAX_C) begin
            // Oversize: close the frame now and swallow the rest until dv falls.
            state      <= DROP;
            rx_eof     <= 1'b1;
            rx_bad     <= 1'b1;
            rx_err_cnt <= sat_inc16(rx_err_cnt);
          end else begin
            cnt <= sat_inc11(cnt);
            crc <= crc_nxt;
            sr  <= {sr[23:0], rxd_r};
            if (er_r) err_flag <= 1'b1;
            // Four bytes of look-behind keep the FCS from ever reaching rx_data.
            if (fill == 3'd4) begin
              rx_data       <= sr[31:24];
              rx_data_valid <= 1'b1;
              rx_sof        <= sof_pend;
              sof_pend      <= 1'b0;
            end else begin
              fill <= fill + 3'd1;
            end
          end
        end
        DROP: begin
          if (!dv_r) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_emac_rx_gtx.sv
// Bench for emac_rx_gtx: frames are built with a real FCS and the expected
// beat/eof stream is derived from frame length, FCS match and rx_er.
module tb_emac_rx_gtx;
  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1518;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  gmii_rxd = 8'h00;
  logic        gmii_rx_dv = 1'b0;
  logic        gmii_rx_er = 1'b0;
  logic [7:0]  rx_data;
  logic        rx_data_valid, rx_sof, rx_eof, rx_good, rx_bad;
  logic [15:0] rx_frame_cnt, rx_err_cnt;

  emac_rx_gtx #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .gmii_rxd(gmii_rxd), .gmii_rx_dv(gmii_rx_dv),
    .gmii_rx_er(gmii_rx_er), .rx_data(rx_data), .rx_data_valid(rx_data_valid),
    .rx_sof(rx_sof), .rx_eof(rx_eof), .rx_good(rx_good), .rx_bad(rx_bad),
    .rx_frame_cnt(rx_frame_cnt), .rx_err_cnt(rx_err_cnt)
  );

  always #4 clk = ~clk;

  typedef struct {logic [7:0] d; bit sof; int cyc;} beat_t;
  typedef struct {logic [7:0] d; bit sof;} xbeat_t;
  typedef struct {bit good; int gap;} eof_t;

  beat_t      got_b[$];
  eof_t       got_e[$];
  xbeat_t     exp_b[$];
  bit         exp_e[$];
  logic [7:0] frm[$];
  int cyc = 0, last_beat = 0, glitch = 0, first_cyc = 0;
  int errors = 0, checks = 0, exp_frames = 0, exp_errs = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    beat_t b;
    eof_t  e;
    if (rst_n) begin
      if (rx_data_valid) begin
        b.d = rx_data; b.sof = rx_sof; b.cyc = cyc;
        got_b.push_back(b);
        last_beat = cyc;
      end
      if (rx_eof) begin
        e.good = rx_good; e.gap = cyc - last_beat;
        got_e.push_back(e);
      end
      if (((rx_good || rx_bad) && !rx_eof) || (rx_eof && (rx_data_valid || rx_good == rx_bad)) ||
          (rx_sof && !rx_data_valid))
        glitch++;
    end
  end

  function automatic logic [31:0] crc_of(int n);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c ^= {24'h0, frm[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  function automatic logic [7:0] junk();
    case ($urandom_range(0, 3))
      0: return 8'hFD;
      1: return 8'hF7;
      2: return 8'hBC;
      default: return 8'h07;
    endcase
  endfunction

  // Payload of len-4 bytes followed by its FCS (complemented CRC, LSB first).
  task automatic build(int len, bit rnd);
    logic [31:0] f;
    frm.delete();
    for (int i = 0; i < len - 4; i++) frm.push_back(rnd ? 8'($urandom) : 8'(i));
    f = ~crc_of(len - 4);
    for (int i = 0; i < 4; i++) frm.push_back(f[8*i +: 8]);
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      gmii_rx_dv = 1'b0; gmii_rx_er = 1'b0; gmii_rxd = junk();
    end
  endtask

  task automatic send(int pre, int er_at);
    for (int i = 0; i < pre; i++) begin
      @(negedge clk); gmii_rx_dv = 1'b1; gmii_rx_er = 1'b0; gmii_rxd = 8'h55;
    end
    @(negedge clk); gmii_rx_dv = 1'b1; gmii_rxd = 8'hD5;
    for (int i = 0; i < frm.size(); i++) begin
      @(negedge clk);
      gmii_rxd = frm[i]; gmii_rx_er = (i == er_at);
      if (i == 0) first_cyc = cyc;
    end
    @(negedge clk); gmii_rx_dv = 1'b0; gmii_rx_er = 1'b0; gmii_rxd = junk();
  endtask

  // Expected outcome of one properly framed transfer of frm.
  task automatic model(int er_at);
    int  n = frm.size();
    bit  fcs_ok, good;
    xbeat_t x;
    if (n > MAX_LEN) begin
      for (int i = 0; i < MAX_LEN - 4; i++) begin x.d = frm[i]; x.sof = (i == 0); exp_b.push_back(x); end
      exp_e.push_back(1'b0);
      if (exp_errs < 65535) exp_errs++;
    end else if (n >= 5) begin
      for (int i = 0; i < n - 4; i++) begin x.d = frm[i]; x.sof = (i == 0); exp_b.push_back(x); end
      fcs_ok = ({frm[n-1], frm[n-2], frm[n-3], frm[n-4]} == ~crc_of(n - 4));
      good = fcs_ok && n >= MIN_LEN && (er_at < 0 || er_at >= n);
      exp_e.push_back(good);
      if (good) begin if (exp_frames < 65535) exp_frames++; end
      else if (exp_errs < 65535) exp_errs++;
    end else if (exp_errs < 65535) exp_errs++;
  endtask

  task automatic clear();
    got_b.delete(); got_e.delete(); exp_b.delete(); exp_e.delete(); glitch = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    checks++;
    if ({rx_data, rx_data_valid, rx_sof, rx_eof, rx_good, rx_bad} !== 13'h0) begin
      errors++; $display("FAIL reset_outs: got %h want 0", {rx_data, rx_data_valid, rx_sof, rx_eof, rx_good, rx_bad});
    end
    checks++;
    if ({rx_frame_cnt, rx_err_cnt} !== 32'h0) begin
      errors++; $display("FAIL reset_cnts: got %h want 0", {rx_frame_cnt, rx_err_cnt});
    end
    rst_n = 1'b1;
    idle(4);
    checks++;
    if ({rx_data_valid, rx_eof, rx_frame_cnt, rx_err_cnt} !== 34'h0) begin
      errors++; $display("FAIL post_reset_idle: got %h want 0", {rx_data_valid, rx_eof, rx_frame_cnt, rx_err_cnt});
    end
  endtask

  task automatic test_min_good();
    int lat;
    clear();
    build(64, 1'b0); model(-1); send(7, -1); idle(10);
    lat = (got_b.size() > 0) ? got_b[0].cyc - first_cyc : -1;
    checks++; if (lat !== 6) begin errors++; $display("FAIL min_latency: got %0d want 6", lat); end
    checks++;
    if (got_b.size() !== exp_b.size()) begin errors++; $display("FAIL min_beats: got %0d want %0d", got_b.size(), exp_b.size()); end
    else for (int i = 0; i < exp_b.size(); i++) begin
      checks++;
      if (got_b[i].d !== exp_b[i].d || got_b[i].sof !== exp_b[i].sof) begin
        errors++; $display("FAIL min_beat[%0d]: got %h/%0d want %h/%0d", i, got_b[i].d, got_b[i].sof, exp_b[i].d, exp_b[i].sof);
      end
      if (i > 0) begin
        checks++; if (got_b[i].cyc !== got_b[i-1].cyc + 1) begin errors++; $display("FAIL min_gap[%0d]: got %0d want %0d", i, got_b[i].cyc, got_b[i-1].cyc + 1); end
      end
    end
    checks++;
    if (got_e.size() !== 1 || got_e[0].good !== 1'b1 || got_e[0].gap !== 1) begin
      errors++; $display("FAIL min_eof: got n=%0d good=%0d want n=1 good=1 gap=1", got_e.size(), got_e.size() ? got_e[0].good : 0);
    end
    checks++; if (rx_frame_cnt !== 16'd1 || rx_err_cnt !== 16'd0) begin errors++; $display("FAIL min_cnts: got %0d/%0d want 1/0", rx_frame_cnt, rx_err_cnt); end
    checks++; if (glitch !== 0) begin errors++; $display("FAIL min_glitch: got %0d want 0", glitch); end
  endtask

  task automatic test_crc_err();
    clear();
    build(64, 1'b0); frm[63] = frm[63] ^ 8'h01; model(-1); send(7, -1); idle(10);
    checks++;
    if (got_b.size() !== exp_b.size()) begin errors++; $display("FAIL crc_beats: got %0d want %0d", got_b.size(), exp_b.size()); end
    else for (int i = 0; i < exp_b.size(); i++) begin
      checks++;
      if (got_b[i].d !== exp_b[i].d || got_b[i].sof !== exp_b[i].sof) begin
        errors++; $display("FAIL crc_beat[%0d]: got %h want %h", i, got_b[i].d, exp_b[i].d);
      end
    end
    checks++;
    if (got_e.size() !== 1 || got_e[0].good !== 1'b0) begin errors++; $display("FAIL crc_eof: got n=%0d want one bad eof", got_e.size()); end
    checks++; if (rx_frame_cnt !== 16'd1 || rx_err_cnt !== 16'd1) begin errors++; $display("FAIL crc_cnts: got %0d/%0d want 1/1", rx_frame_cnt, rx_err_cnt); end
    checks++; if (glitch !== 0) begin errors++; $display("FAIL crc_glitch: got %0d want 0", glitch); end
  endtask

  task automatic test_runt_short();
    clear();
    build(63, 1'b1); model(-1); send(7, -1); idle(8);
    frm.delete(); repeat (3) frm.push_back(8'($urandom)); model(-1); send(7, -1); idle(8);
    build(64, 1'b1); model(-1); send(1, -1); idle(10);
    checks++;
    if (got_b.size() !== exp_b.size()) begin errors++; $display("FAIL runt_beats: got %0d want %0d", got_b.size(), exp_b.size()); end
    else for (int i = 0; i < exp_b.size(); i++) begin
      checks++;
      if (got_b[i].d !== exp_b[i].d || got_b[i].sof !== exp_b[i].sof) begin
        errors++; $display("FAIL runt_beat[%0d]: got %h/%0d want %h/%0d", i, got_b[i].d, got_b[i].sof, exp_b[i].d, exp_b[i].sof);
      end
    end
    checks++;
    if (got_e.size() !== exp_e.size()) begin errors++; $display("FAIL runt_eofs: got %0d want %0d", got_e.size(), exp_e.size()); end
    else for (int i = 0; i < exp_e.size(); i++) begin
      checks++;
      if (got_e[i].good !== exp_e[i] || got_e[i].gap !== 1) begin errors++; $display("FAIL runt_eof[%0d]: got %0d/%0d want %0d/1", i, got_e[i].good, got_e[i].gap, exp_e[i]); end
    end
    checks++;
    if (rx_frame_cnt !== 16'(exp_frames) || rx_err_cnt !== 16'(exp_errs)) begin
      errors++; $display("FAIL runt_cnts: got %0d/%0d want %0d/%0d", rx_frame_cnt, rx_err_cnt, exp_frames, exp_errs);
    end
    checks++; if (glitch !== 0) begin errors++; $display("FAIL runt_glitch: got %0d want 0", glitch); end
  endtask

  task automatic test_oversize_er();
    clear();
    build(MAX_LEN + 1, 1'b1); model(-1); send(7, -1); idle(10);
    build(100, 1'b1); model(19); send(7, 19); idle(10);
    checks++;
    if (got_b.size() !== exp_b.size()) begin errors++; $display("FAIL over_beats: got %0d want %0d", got_b.size(), exp_b.size()); end
    else for (int i = 0; i < exp_b.size(); i++) begin
      checks++;
      if (got_b[i].d !== exp_b[i].d || got_b[i].sof !== exp_b[i].sof) begin
        errors++; $display("FAIL over_beat[%0d]: got %h want %h", i, got_b[i].d, exp_b[i].d);
      end
      if (i > 0 && !exp_b[i].sof) begin
        checks++; if (got_b[i].cyc !== got_b[i-1].cyc + 1) begin errors++; $display("FAIL over_gap[%0d]: got %0d want %0d", i, got_b[i].cyc, got_b[i-1].cyc + 1); end
      end
    end
    checks++;
    if (got_e.size() !== exp_e.size()) begin errors++; $display("FAIL over_eofs: got %0d want %0d", got_e.size(), exp_e.size()); end
    else for (int i = 0; i < exp_e.size(); i++) begin
      checks++;
      if (got_e[i].good !== exp_e[i] || got_e[i].gap !== 1) begin errors++; $display("FAIL over_eof[%0d]: got %0d/%0d want %0d/1", i, got_e[i].good, got_e[i].gap, exp_e[i]); end
    end
    checks++;
    if (rx_frame_cnt !== 16'(exp_frames) || rx_err_cnt !== 16'(exp_errs)) begin
      errors++; $display("FAIL over_cnts: got %0d/%0d want %0d/%0d", rx_frame_cnt, rx_err_cnt, exp_frames, exp_errs);
    end
    checks++; if (glitch !== 0) begin errors++; $display("FAIL over_glitch: got %0d want 0", glitch); end
  endtask

  task automatic test_back_to_back();
    int len, er_at;
    clear();
    build(64, 1'b1); model(-1); send(7, -1);
    build(64, 1'b1); model(-1); send(7, -1); idle(3);
    build(64, 1'b1); send(0, -1); idle(2);
    for (int i = 0; i < 3; i++) begin @(negedge clk); gmii_rx_dv = 1'b1; gmii_rxd = 8'h55; end
    @(negedge clk); gmii_rxd = 8'h44;
    for (int i = 0; i < 20; i++) begin @(negedge clk); gmii_rxd = 8'($urandom); end
    idle(2);
    for (int f = 0; f < 8; f++) begin
      len = $urandom_range(5, 150);
      build(len, 1'b1);
      if ($urandom_range(0, 3) == 0) frm[len-1] = frm[len-1] ^ 8'h80;
      er_at = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len - 1) : -1;
      model(er_at); send($urandom_range(1, 7), er_at); idle($urandom_range(0, 3));
    end
    idle(10);
    checks++;
    if (got_b.size() !== exp_b.size()) begin errors++; $display("FAIL b2b_beats: got %0d want %0d", got_b.size(), exp_b.size()); end
    else for (int i = 0; i < exp_b.size(); i++) begin
      checks++;
      if (got_b[i].d !== exp_b[i].d || got_b[i].sof !== exp_b[i].sof) begin
        errors++; $display("FAIL b2b_beat[%0d]: got %h/%0d want %h/%0d", i, got_b[i].d, got_b[i].sof, exp_b[i].d, exp_b[i].sof);
      end
      if (i > 0 && !exp_b[i].sof) begin
        checks++; if (got_b[i].cyc !== got_b[i-1].cyc + 1) begin errors++; $display("FAIL b2b_gap[%0d]: got %0d want %0d", i, got_b[i].cyc, got_b[i-1].cyc + 1); end
      end
    end
    checks++;
    if (got_e.size() !== exp_e.size()) begin errors++; $display("FAIL b2b_eofs: got %0d want %0d", got_e.size(), exp_e.size()); end
    else for (int i = 0; i < exp_e.size(); i++) begin
      checks++;
      if (got_e[i].good !== exp_e[i] || got_e[i].gap !== 1) begin errors++; $display("FAIL b2b_eof[%0d]: got %0d/%0d want %0d/1", i, got_e[i].good, got_e[i].gap, exp_e[i]); end
    end
    checks++;
    if (rx_frame_cnt !== 16'(exp_frames) || rx_err_cnt !== 16'(exp_errs)) begin
      errors++; $display("FAIL b2b_cnts: got %0d/%0d want %0d/%0d", rx_frame_cnt, rx_err_cnt, exp_frames, exp_errs);
    end
    checks++; if (glitch !== 0) begin errors++; $display("FAIL b2b_glitch: got %0d want 0", glitch); end
  endtask

  task automatic test_reset_mid();
    clear();
    build(64, 1'b0);
    for (int i = 0; i < 7; i++) begin @(negedge clk); gmii_rx_dv = 1'b1; gmii_rxd = 8'h55; end
    @(negedge clk); gmii_rxd = 8'hD5;
    for (int i = 0; i < frm.size(); i++) begin
      @(negedge clk); gmii_rxd = frm[i];
      if (i == 30) begin
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({rx_data, rx_data_valid, rx_sof, rx_eof, rx_good, rx_bad, rx_frame_cnt, rx_err_cnt} !== 45'h0) begin
          errors++; $display("FAIL mid_reset_outs: got %h want 0", {rx_data, rx_data_valid, rx_sof, rx_eof, rx_good, rx_bad, rx_frame_cnt, rx_err_cnt});
        end
        clear(); exp_frames = 0; exp_errs = 0;
      end
      if (i == 41) rst_n = 1'b1;
    end
    idle(10);
    checks++;
    if (got_b.size() !== 0 || got_e.size() !== 0) begin errors++; $display("FAIL mid_tail: got %0d beats %0d eofs want 0/0", got_b.size(), got_e.size()); end
    checks++; if ({rx_frame_cnt, rx_err_cnt} !== 32'h0) begin errors++; $display("FAIL mid_cnts: got %h want 0", {rx_frame_cnt, rx_err_cnt}); end
    build(64, 1'b1); model(-1); send(7, -1); idle(10);
    checks++;
    if (got_b.size() !== exp_b.size()) begin errors++; $display("FAIL mid_beats: got %0d want %0d", got_b.size(), exp_b.size()); end
    else for (int i = 0; i < exp_b.size(); i++) begin
      checks++;
      if (got_b[i].d !== exp_b[i].d || got_b[i].sof !== exp_b[i].sof) begin
        errors++; $display("FAIL mid_beat[%0d]: got %h want %h", i, got_b[i].d, exp_b[i].d);
      end
    end
    checks++;
    if (got_e.size() !== 1 || got_e[0].good !== 1'b1) begin errors++; $display("FAIL mid_eof: got n=%0d want one good eof", got_e.size()); end
    checks++; if (rx_frame_cnt !== 16'd1 || rx_err_cnt !== 16'd0) begin errors++; $display("FAIL mid_after_cnts: got %0d/%0d want 1/0", rx_frame_cnt, rx_err_cnt); end
    checks++; if (glitch !== 0) begin errors++; $display("FAIL mid_glitch: got %0d want 0", glitch); end
  endtask

  initial begin
    test_reset();
    test_min_good();
    test_crc_err();
    test_runt_short();
    test_oversize_er();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
